// File: rtl/mrv1_th_sync_if.sv
// ----------------------------------------------------------------------------
// mrv1_th_sync_if
// Request/response bundle between the thread-control execution unit, the
// thread-synchronisation responder and fetch. Signal suffixes are given from
// the responder's point of view.
//
// Handshake rule for every channel in this bundle: a transfer happens in a
// cycle where the valid and the matching ready are both high at the rising
// clock edge. Valid never depends on ready. While valid is high and ready is
// low, the presenting side keeps its payload stable.
//
// Signals:
//   tw_ctl_rdy_o              responder can take a wspawn/barrier request
//   tw_ctl_wspawn_vld_i       wspawn request valid
//   tw_ctl_wspawn_wmask_i     threads to spawn
//   tw_ctl_wspawn_pc_i        start PC of spawned threads
//   tw_ctl_barrier_vld_i      barrier arrival valid
//   tw_ctl_barrier_id_i       barrier slot
//   tw_ctl_barrier_size_m1_i  participating threads minus one
//   tw_ctl_barrier_wid_i      arriving thread id
//   spawn_vld_o               spawn presented to fetch
//   spawn_wid_o               thread being spawned
//   spawn_pc_o                its start PC
//   spawn_rdy_i               fetch accepts the spawn
// Modports: slave = responder, master = thread-control unit plus fetch.
// ----------------------------------------------------------------------------
interface mrv1_th_sync_if #(
    parameter int NUM_THREADS_P  = 8,
    parameter int num_barriers_p = 8
);
    localparam int wid_width_lp        = $clog2(NUM_THREADS_P);
    localparam int barrier_id_width_lp = $clog2(num_barriers_p);

    logic                           tw_ctl_rdy_o;
    logic                           tw_ctl_wspawn_vld_i;
    logic [NUM_THREADS_P-1:0]       tw_ctl_wspawn_wmask_i;
    logic [31:0]                    tw_ctl_wspawn_pc_i;
    logic                           tw_ctl_barrier_vld_i;
    logic [barrier_id_width_lp-1:0] tw_ctl_barrier_id_i;
    logic [wid_width_lp-1:0]        tw_ctl_barrier_size_m1_i;
    logic [wid_width_lp-1:0]        tw_ctl_barrier_wid_i;
    logic                           spawn_vld_o;
    logic [wid_width_lp-1:0]        spawn_wid_o;
    logic [31:0]                    spawn_pc_o;
    logic                           spawn_rdy_i;

    modport slave (
        output tw_ctl_rdy_o,
        input  tw_ctl_wspawn_vld_i,
        input  tw_ctl_wspawn_wmask_i,
        input  tw_ctl_wspawn_pc_i,
        input  tw_ctl_barrier_vld_i,
        input  tw_ctl_barrier_id_i,
        input  tw_ctl_barrier_size_m1_i,
        input  tw_ctl_barrier_wid_i,
        output spawn_vld_o,
        output spawn_wid_o,
        output spawn_pc_o,
        input  spawn_rdy_i
    );

    modport master (
        input  tw_ctl_rdy_o,
        output tw_ctl_wspawn_vld_i,
        output tw_ctl_wspawn_wmask_i,
        output tw_ctl_wspawn_pc_i,
        output tw_ctl_barrier_vld_i,
        output tw_ctl_barrier_id_i,
        output tw_ctl_barrier_size_m1_i,
        output tw_ctl_barrier_wid_i,
        input  spawn_vld_o,
        input  spawn_wid_o,
        input  spawn_pc_o,
        output spawn_rdy_i
    );
endinterface

// File: rtl/mrv1_th_sync.sv
// ----------------------------------------------------------------------------
// mrv1_th_sync
// Thread-synchronisation responder of the mtcore scheduler. Accepts wspawn
// and barrier requests, keeps the active and stalled thread masks, hands
// spawned threads to fetch one per handshake and releases barrier waiters
// when a barrier slot fills.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   ctl_if           request/spawn bundle (slave side), see mrv1_th_sync_if
//   th_exit_vld_i    thread termination
//   th_exit_wid_i    terminating thread id
//   release_vld_o    one-cycle barrier-release pulse
//   release_mask_o   threads released (holds between pulses)
//   th_active_o      active-thread mask
//   th_stalled_o     threads waiting at a barrier
//   dbg_state_o      spawn FSM state (0 = IDLE, 1 = SPAWN)
// ----------------------------------------------------------------------------
module mrv1_th_sync #(
    parameter  int NUM_THREADS_P       = 8,
    parameter  int num_barriers_p      = 8,
    localparam int wid_width_lp        = $clog2(NUM_THREADS_P),
    localparam int barrier_id_width_lp = $clog2(num_barriers_p)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    mrv1_th_sync_if.slave            ctl_if,
    input  logic                     th_exit_vld_i,
    input  logic [wid_width_lp-1:0]  th_exit_wid_i,
    output logic                     release_vld_o,
    output logic [NUM_THREADS_P-1:0] release_mask_o,
    output logic [NUM_THREADS_P-1:0] th_active_o,
    output logic [NUM_THREADS_P-1:0] th_stalled_o,
    output logic                     dbg_state_o
);
    localparam int cnt_width_lp = wid_width_lp + 1;

    typedef enum logic {
        IDLE_S  = 1'b0,
        SPAWN_S = 1'b1
    } state_e;

    state_e                     state_q;
    logic [NUM_THREADS_P-1:0]   pend_q;
    logic                       spawn_vld_q;
    logic [wid_width_lp-1:0]    spawn_wid_q;
    logic [31:0]                spawn_pc_q;

    logic [NUM_THREADS_P-1:0]   active_q, active_d;
    logic [NUM_THREADS_P-1:0]   stalled_q, stalled_d;
    logic                       release_vld_q, release_vld_d;
    logic [NUM_THREADS_P-1:0]   release_mask_q, release_mask_d;

    logic [cnt_width_lp-1:0]    cnt_q  [num_barriers_p];
    logic [cnt_width_lp-1:0]    cnt_d  [num_barriers_p];
    logic [NUM_THREADS_P-1:0]   mask_q [num_barriers_p];
    logic [NUM_THREADS_P-1:0]   mask_d [num_barriers_p];
    logic [wid_width_lp-1:0]    size_q [num_barriers_p];
    logic [wid_width_lp-1:0]    size_d [num_barriers_p];

    logic                       rdy;
    logic                       wspawn_acc;
    logic                       barrier_acc;
    logic                       spawn_fire;
    logic [NUM_THREADS_P-1:0]   new_pend;
    logic [NUM_THREADS_P-1:0]   spawn_onehot;
    logic [NUM_THREADS_P-1:0]   pend_left;
    logic [NUM_THREADS_P-1:0]   arrive_onehot;
    logic [NUM_THREADS_P-1:0]   done_mask;
    logic [wid_width_lp-1:0]    cur_size;
    logic [cnt_width_lp-1:0]    cnt_next;

    // Index of the lowest set bit; spawn order is ascending thread id.
    function automatic logic [wid_width_lp-1:0] lowest_idx(input logic [NUM_THREADS_P-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_THREADS_P - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = wid_width_lp'(i);
        end
    endfunction

    // Requests are only taken while no spawn sequence is in flight.
    assign rdy         = (state_q == IDLE_S);
    assign wspawn_acc  = ctl_if.tw_ctl_wspawn_vld_i  && rdy;
    assign barrier_acc = ctl_if.tw_ctl_barrier_vld_i && rdy;
    assign spawn_fire  = spawn_vld_q && ctl_if.spawn_rdy_i;

    assign new_pend      = ctl_if.tw_ctl_wspawn_wmask_i & ~active_q;
    assign spawn_onehot  = {{(NUM_THREADS_P-1){1'b0}}, 1'b1} << spawn_wid_q;
    assign pend_left     = pend_q & ~spawn_onehot;
    assign arrive_onehot = {{(NUM_THREADS_P-1){1'b0}}, 1'b1} << ctl_if.tw_ctl_barrier_wid_i;

    // Spawn sequencer: spawn outputs are registered so fetch sees a stable
    // wid/pc for as long as it stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE_S;
            pend_q      <= '0;
            spawn_vld_q <= 1'b0;
            spawn_wid_q <= '0;
            spawn_pc_q  <= '0;
        end else begin
            case (state_q)
                IDLE_S: begin
                    if (wspawn_acc) begin
                        pend_q     <= new_pend;
                        spawn_pc_q <= ctl_if.tw_ctl_wspawn_pc_i;
                        // Spawning only already-active threads is a no-op.
                        if (new_pend != '0) begin
                            state_q     <= SPAWN_S;
                            spawn_vld_q <= 1'b1;
                            spawn_wid_q <= lowest_idx(new_pend);
                        end
                    end
                end
                SPAWN_S: begin
                    if (spawn_fire) begin
                        pend_q <= pend_left;
                        if (pend_left == '0) begin
                            state_q     <= IDLE_S;
                            spawn_vld_q <= 1'b0;
                        end else begin
                            spawn_wid_q <= lowest_idx(pend_left);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE_S;
                    spawn_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Barrier bookkeeping and thread masks.
    always_comb begin
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        size_d         = size_q;
        active_d       = active_q;
        stalled_d      = stalled_q;
        release_vld_d  = 1'b0;
        release_mask_d = release_mask_q;
        cur_size       = '0;
        cnt_next       = '0;
        done_mask      = '0;

        // A thread already waiting cannot arrive again; the count is untouched.
        if (barrier_acc && !stalled_q[ctl_if.tw_ctl_barrier_wid_i]) begin
            // The first arrival of a generation fixes the barrier size.
            cur_size = (cnt_q[ctl_if.tw_ctl_barrier_id_i] == '0)
                     ? ctl_if.tw_ctl_barrier_size_m1_i
                     : size_q[ctl_if.tw_ctl_barrier_id_i];
            size_d[ctl_if.tw_ctl_barrier_id_i] = cur_size;
            cnt_next = cnt_q[ctl_if.tw_ctl_barrier_id_i] + cnt_width_lp'(1);
            if (cnt_next == ({1'b0, cur_size} + cnt_width_lp'(1))) begin
                // Completion: slot is free for a new generation next cycle and
                // the waiters (including this arrival) never stay stalled.
                done_mask = mask_q[ctl_if.tw_ctl_barrier_id_i] | arrive_onehot;
                cnt_d[ctl_if.tw_ctl_barrier_id_i]  = '0;
                mask_d[ctl_if.tw_ctl_barrier_id_i] = '0;
                release_vld_d  = 1'b1;
                release_mask_d = done_mask;
                stalled_d      = stalled_d & ~done_mask;
            end else begin
                cnt_d[ctl_if.tw_ctl_barrier_id_i]  = cnt_next;
                mask_d[ctl_if.tw_ctl_barrier_id_i] = mask_q[ctl_if.tw_ctl_barrier_id_i] | arrive_onehot;
                stalled_d = stalled_d | arrive_onehot;
            end
        end

        if (th_exit_vld_i) begin
            active_d[th_exit_wid_i]  = 1'b0;
            stalled_d[th_exit_wid_i] = 1'b0;
        end

        // Applied after the exit so a spawn of the same thread wins.
        if (spawn_fire) begin
            active_d = active_d | spawn_onehot;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q       <= {{(NUM_THREADS_P-1){1'b0}}, 1'b1};
            stalled_q      <= '0;
            release_vld_q  <= 1'b0;
            release_mask_q <= '0;
            for (int b = 0; b < num_barriers_p; b++) begin
                cnt_q[b]  <= '0;
                mask_q[b] <= '0;
                size_q[b] <= '0;
            end
        end else begin
            active_q       <= active_d;
            stalled_q      <= stalled_d;
            release_vld_q  <= release_vld_d;
            release_mask_q <= release_mask_d;
            for (int b = 0; b < num_barriers_p; b++) begin
                cnt_q[b]  <= cnt_d[b];
                mask_q[b] <= mask_d[b];
                size_q[b] <= size_d[b];
            end
        end
    end

    assign ctl_if.tw_ctl_rdy_o = rdy;
    assign ctl_if.spawn_vld_o  = spawn_vld_q;
    assign ctl_if.spawn_wid_o  = spawn_wid_q;
    assign ctl_if.spawn_pc_o   = spawn_pc_q;
    assign release_vld_o       = release_vld_q;
    assign release_mask_o      = release_mask_q;
    assign th_active_o         = active_q;
    assign th_stalled_o        = stalled_q;
    assign dbg_state_o         = (state_q == SPAWN_S);

endmodule

// File: tb/tb_mrv1_th_sync.sv
module tb_mrv1_th_sync;
    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic       th_exit_vld;
    logic [2:0] th_exit_wid;
    logic       release_vld;
    logic [7:0] release_mask;
    logic [7:0] th_active;
    logic [7:0] th_stalled;
    logic       dbg_state;

    int total = 0;
    int bad   = 0;

    mrv1_th_sync_if #(.NUM_THREADS_P(N), .num_barriers_p(8)) ctl_if ();

    mrv1_th_sync #(.NUM_THREADS_P(N), .num_barriers_p(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ctl_if         (ctl_if),
        .th_exit_vld_i  (th_exit_vld),
        .th_exit_wid_i  (th_exit_wid),
        .release_vld_o  (release_vld),
        .release_mask_o (release_mask),
        .th_active_o    (th_active),
        .th_stalled_o   (th_stalled),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_active;
    logic [7:0]  m_stalled;
    bit          m_rel_vld;
    logic [7:0]  m_rel_mask;
    logic [31:0] m_pc;
    int          spawn_q[$];      // threads still to be handed to fetch, in order
    int          bar_cnt[8];      // arrivals so far in the current generation
    int          bar_need[8];     // participants required by the generation
    logic [7:0]  bar_who[8];      // threads waiting on the slot

    task automatic model_reset();
        m_active   = 8'h01;
        m_stalled  = 8'h00;
        m_rel_vld  = 1'b0;
        m_rel_mask = 8'h00;
        m_pc       = 32'h0;
        spawn_q.delete();
        for (int b = 0; b < 8; b++) begin
            bar_cnt[b]  = 0;
            bar_need[b] = 0;
            bar_who[b]  = 8'h00;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic [7:0] act0;
        logic [7:0] stl0;
        bit         idle0;
        int         b;
        int         w;
        act0      = m_active;
        stl0      = m_stalled;
        idle0     = (spawn_q.size() == 0);
        m_rel_vld = 1'b0;
        if (ctl_if.tw_ctl_barrier_vld_i && idle0 && !stl0[ctl_if.tw_ctl_barrier_wid_i]) begin
            b = int'(ctl_if.tw_ctl_barrier_id_i);
            w = int'(ctl_if.tw_ctl_barrier_wid_i);
            if (bar_cnt[b] == 0) bar_need[b] = int'(ctl_if.tw_ctl_barrier_size_m1_i) + 1;
            bar_cnt[b] = bar_cnt[b] + 1;
            bar_who[b][w] = 1'b1;
            if (bar_cnt[b] == bar_need[b]) begin
                m_rel_vld  = 1'b1;
                m_rel_mask = bar_who[b];
                m_stalled  = m_stalled & ~bar_who[b];
                bar_cnt[b] = 0;
                bar_who[b] = 8'h00;
            end else begin
                m_stalled[w] = 1'b1;
            end
        end
        if (th_exit_vld) begin
            m_active[th_exit_wid]  = 1'b0;
            m_stalled[th_exit_wid] = 1'b0;
        end
        if (!idle0 && ctl_if.spawn_rdy_i) begin
            m_active[spawn_q[0]] = 1'b1;
            void'(spawn_q.pop_front());
        end
        if (ctl_if.tw_ctl_wspawn_vld_i && idle0) begin
            m_pc = ctl_if.tw_ctl_wspawn_pc_i;
            for (int i = 0; i < N; i++) begin
                if (ctl_if.tw_ctl_wspawn_wmask_i[i] && !act0[i]) spawn_q.push_back(i);
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit busy;
        busy = (spawn_q.size() != 0);
        chk("rdy",          {63'd0, ctl_if.tw_ctl_rdy_o}, {63'd0, !busy});
        chk("dbg_state",    {63'd0, dbg_state},           {63'd0, busy});
        chk("spawn_vld",    {63'd0, ctl_if.spawn_vld_o},  {63'd0, busy});
        if (busy) begin
            chk("spawn_wid", {61'd0, ctl_if.spawn_wid_o}, 64'(spawn_q[0]));
            chk("spawn_pc",  {32'd0, ctl_if.spawn_pc_o},  {32'd0, m_pc});
        end
        chk("th_active",    {56'd0, th_active},    {56'd0, m_active});
        chk("th_stalled",   {56'd0, th_stalled},   {56'd0, m_stalled});
        chk("release_vld",  {63'd0, release_vld},  {63'd0, m_rel_vld});
        chk("release_mask", {56'd0, release_mask}, {56'd0, m_rel_mask});
    endtask

    // ---------------- drivers ----------------
    task automatic clear_req();
        ctl_if.tw_ctl_wspawn_vld_i      = 1'b0;
        ctl_if.tw_ctl_wspawn_wmask_i    = 8'h00;
        ctl_if.tw_ctl_wspawn_pc_i       = 32'h0;
        ctl_if.tw_ctl_barrier_vld_i     = 1'b0;
        ctl_if.tw_ctl_barrier_id_i      = 3'd0;
        ctl_if.tw_ctl_barrier_size_m1_i = 3'd0;
        ctl_if.tw_ctl_barrier_wid_i     = 3'd0;
        th_exit_vld                     = 1'b0;
        th_exit_wid                     = 3'd0;
    endtask

    // One clock with the inputs as currently driven, then full comparison.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_barrier(input logic [2:0] id, input logic [2:0] sz, input logic [2:0] wid);
        ctl_if.tw_ctl_barrier_vld_i     = 1'b1;
        ctl_if.tw_ctl_barrier_id_i      = id;
        ctl_if.tw_ctl_barrier_size_m1_i = sz;
        ctl_if.tw_ctl_barrier_wid_i     = wid;
    endtask

    task automatic set_wspawn(input logic [7:0] wmask, input logic [31:0] pc);
        ctl_if.tw_ctl_wspawn_vld_i   = 1'b1;
        ctl_if.tw_ctl_wspawn_wmask_i = wmask;
        ctl_if.tw_ctl_wspawn_pc_i    = pc;
    endtask

    task automatic do_exit(input logic [2:0] wid);
        th_exit_vld = 1'b1;
        th_exit_wid = wid;
        cycle();
        clear_req();
    endtask

    task automatic arrive(input logic [2:0] id, input logic [2:0] sz, input logic [2:0] wid);
        set_barrier(id, sz, wid);
        cycle();
        clear_req();
    endtask

    // ---------------- directed steps + random phase ----------------
    initial begin
        rst_n              = 1'b0;
        ctl_if.spawn_rdy_i = 1'b0;
        clear_req();
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        chk("reset_active",  {56'd0, th_active},  64'h01);
        chk("reset_stalled", {56'd0, th_stalled}, 64'h00);
        chk("reset_svld",    {63'd0, ctl_if.spawn_vld_o}, 64'h0);
        chk("reset_swid",    {61'd0, ctl_if.spawn_wid_o}, 64'h0);
        chk("reset_spc",     {32'd0, ctl_if.spawn_pc_o},  64'h0);
        chk("reset_rvld",    {63'd0, release_vld},  64'h0);
        chk("reset_rmask",   {56'd0, release_mask}, 64'h0);
        chk("reset_rdy",     {63'd0, ctl_if.tw_ctl_rdy_o}, 64'h1);
        rst_n = 1'b1;
        cycle();

        // Spawn all threads back to back
        ctl_if.spawn_rdy_i = 1'b1;
        set_wspawn(8'hFF, 32'h8000_0100);
        cycle();
        clear_req();
        for (int k = 1; k <= 7; k++) begin
            chk("seq_wid", {61'd0, ctl_if.spawn_wid_o}, 64'(k));
            chk("seq_pc",  {32'd0, ctl_if.spawn_pc_o},  64'h8000_0100);
            chk("seq_rdy", {63'd0, ctl_if.tw_ctl_rdy_o}, 64'h0);
            cycle();
        end
        chk("seq_active", {56'd0, th_active}, 64'hFF);
        chk("seq_idle",   {63'd0, ctl_if.tw_ctl_rdy_o}, 64'h1);

        // Spawn with a fetch stall in the middle
        do_exit(3'd2);
        do_exit(3'd3);
        ctl_if.spawn_rdy_i = 1'b0;
        set_wspawn(8'h0C, 32'h0000_4000);
        cycle();
        clear_req();
        chk("stall_wid2", {61'd0, ctl_if.spawn_wid_o}, 64'd2);
        ctl_if.spawn_rdy_i = 1'b1;
        cycle();
        chk("stall_wid3a", {61'd0, ctl_if.spawn_wid_o}, 64'd3);
        ctl_if.spawn_rdy_i = 1'b0;
        cycle();
        chk("stall_wid3b", {61'd0, ctl_if.spawn_wid_o}, 64'd3);
        chk("stall_vld",   {63'd0, ctl_if.spawn_vld_o}, 64'h1);
        ctl_if.spawn_rdy_i = 1'b1;
        cycle();
        chk("stall_active", {56'd0, th_active}, 64'hFF);

        // Four-thread barrier
        arrive(3'd3, 3'd3, 3'd0);
        arrive(3'd3, 3'd3, 3'd1);
        arrive(3'd3, 3'd3, 3'd2);
        chk("bar4_stalled", {56'd0, th_stalled}, 64'h07);
        chk("bar4_norel",   {63'd0, release_vld}, 64'h0);
        arrive(3'd3, 3'd3, 3'd5);
        chk("bar4_rvld",    {63'd0, release_vld},  64'h1);
        chk("bar4_rmask",   {56'd0, release_mask}, 64'h27);
        chk("bar4_clear",   {56'd0, th_stalled},   64'h00);
        cycle();
        chk("bar4_pulse",   {63'd0, release_vld},  64'h0);
        chk("bar4_hold",    {56'd0, release_mask}, 64'h27);

        // Single-thread barrier together with a wspawn
        do_exit(3'd1);
        set_barrier(3'd1, 3'd0, 3'd4);
        set_wspawn(8'h02, 32'h0000_0200);
        cycle();
        clear_req();
        chk("dual_rmask", {56'd0, release_mask}, 64'h10);
        chk("dual_rvld",  {63'd0, release_vld},  64'h1);
        chk("dual_swid",  {61'd0, ctl_if.spawn_wid_o}, 64'd1);
        cycle();
        chk("dual_active", {56'd0, th_active}, 64'hFF);

        // Duplicate arrival does not count
        arrive(3'd2, 3'd2, 3'd6);
        arrive(3'd2, 3'd2, 3'd6);
        arrive(3'd2, 3'd2, 3'd7);
        chk("dup_norel",   {63'd0, release_vld}, 64'h0);
        chk("dup_stalled", {56'd0, th_stalled},  64'hC0);
        arrive(3'd2, 3'd2, 3'd0);
        chk("dup_rmask",   {56'd0, release_mask}, 64'hC1);

        // Asynchronous reset while spawning with a barrier half full
        arrive(3'd0, 3'd3, 3'd7);
        do_exit(3'd3);
        do_exit(3'd4);
        ctl_if.spawn_rdy_i = 1'b0;
        set_wspawn(8'h18, 32'h0000_0300);
        cycle();
        clear_req();
        chk("pre_rst_vld", {63'd0, ctl_if.spawn_vld_o}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_svld",    {63'd0, ctl_if.spawn_vld_o}, 64'h0);
        chk("arst_swid",    {61'd0, ctl_if.spawn_wid_o}, 64'h0);
        chk("arst_active",  {56'd0, th_active},  64'h01);
        chk("arst_stalled", {56'd0, th_stalled}, 64'h00);
        chk("arst_rdy",     {63'd0, ctl_if.tw_ctl_rdy_o}, 64'h1);
        chk("arst_rmask",   {56'd0, release_mask}, 64'h00);
        model_reset();
        #3;
        rst_n = 1'b1;
        cycle();
        arrive(3'd0, 3'd1, 3'd0);
        arrive(3'd0, 3'd1, 3'd1);
        chk("post_rst_rmask", {56'd0, release_mask}, 64'h03);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            ctl_if.spawn_rdy_i = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) set_wspawn(8'($urandom), $urandom);
            if ($urandom_range(0, 1) == 0)
                set_barrier(3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) begin
                th_exit_vld = 1'b1;
                th_exit_wid = 3'($urandom_range(0, 7));
            end
            cycle();
            clear_req();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
